flp_accum_seq: RTL and testbench
================================

Name: flp_accum_seq

Overview:
- Sequencer that accumulates a stream of NUM terms (exponent/mantissa pairs) into one running sum, one term at a time.
- Owns no arithmetic. It drives the shared external FLP adder operand ports and captures the adder result after a fixed latency.
- Used to build the pseudo-softmax denominator, which is the sum of exponentiated terms, ahead of normalisation.

Parameters:
- EXP_WIDTH, 9, exponent width; matches the adder.
- MANT_WIDTH, 8, mantissa width; matches the adder.
- CNT_WIDTH, 4, width of the term counter; up to 2^CNT_WIDTH-1 terms.
- ADD_LAT, 2, number of cycles from adder operands presented to adder result valid; must be at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin accumulation; sampled only in IDLE.
- num_terms  in  CNT_WIDTH  number of terms; latched on accepted start.
- in_valid  in  1  term valid.
- in_ready  out  1  controller can accept a term.
- in_exp  in  EXP_WIDTH  term exponent.
- in_mant  in  MANT_WIDTH  term mantissa.
- add_exp1  out  EXP_WIDTH  adder operand 1 exponent (accumulator).
- add_mant1  out  MANT_WIDTH  adder operand 1 mantissa (accumulator).
- add_exp2  out  EXP_WIDTH  adder operand 2 exponent (held term).
- add_mant2  out  MANT_WIDTH  adder operand 2 mantissa (held term).
- add_exp  in  EXP_WIDTH  adder result exponent.
- add_mant  in  MANT_WIDTH  adder result mantissa.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sum is final.
- acc_exp  out  EXP_WIDTH  accumulated exponent.
- acc_mant  out  MANT_WIDTH  accumulated mantissa.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0.
  - acc_exp, acc_mant, held term registers = 0.
  - in_ready=0, busy=0, done=0.
  - Reset mid-operation abandons the sum; no done pulse.
- States: IDLE, FIRST, WAIT_TERM, ADD, DONE.
- IDLE:
  - start=1 latches num_terms.
  - num_terms=0: go to DONE with acc cleared to 0.
  - Otherwise go to FIRST.
  - start is ignored in every other state.
- FIRST:
  - in_ready=1.
  - On in_valid&in_ready, the term loads directly into acc_exp/acc_mant; no add is performed.
  - remaining = num_terms-1.
  - remaining=0: go to DONE; else go to WAIT_TERM.
- WAIT_TERM:
  - in_ready=1.
  - On handshake, the term is captured into the held registers and the state goes to ADD.
- ADD:
  - in_ready=0.
  - add_*1 = acc registers, add_*2 = held registers, held constant for exactly ADD_LAT cycles.
  - On the edge ending the ADD_LAT-th ADD cycle: acc <= {add_exp, add_mant}; remaining decrements.
  - remaining becomes 0: go to DONE; else go to WAIT_TERM.
- DONE:
  - done=1 for one cycle; busy=1; then go to IDLE.
- Operand and output values:
  - Adder operand ports always reflect the acc and held registers, including outside ADD.
  - acc_exp/acc_mant hold their final value in IDLE until the next accepted start.
- Timing:
  - Throughput is one term per ADD_LAT+1 cycles after the first term.
  - in_ready rises again exactly ADD_LAT+1 cycles after the previous accept.
- No combinational path from in_valid to in_ready. in_ready depends on state only.
- No arithmetic in the controller except the counter decrement. Overflow and normalisation belong to the adder.
- in_valid=0 in FIRST or WAIT_TERM: the controller waits indefinitely with no timeout.

Test Plan:
- Bench stub: a pipelined adder model with ADD_LAT stages, using the equal-exponent mantissa add from the FLP adder.
- Reset: assert rst during ADD with ADD_LAT=2 -> next cycle state IDLE, busy=0, acc_exp=0, acc_mant=0, no done pulse; a new start then runs cleanly.
- num_terms=3, terms (exp 3, mant 0x10), (3, 0x20), (3, 0x05), in_valid held high -> accepts at cycles 0, 1, 4; done pulses once; acc_exp=3, acc_mant=0x35.
- num_terms=1, term (7, 0x42) -> no adder operands sampled; done the cycle after the accept; acc = (7, 0x42).
- num_terms=0 -> done one cycle after start; acc = (0, 0x00); in_ready never asserted.
- Stalling source: num_terms=2, second in_valid delayed 5 cycles -> in_ready stays high throughout the gap; operands are stable for the full ADD_LAT window; done exactly ADD_LAT+1 cycles after the second accept.
- start pulsed while busy -> ignored; num_terms is not re-latched; the sum completes unchanged.

Source files
------------

// File: rtl/flp_accum_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : flp_accum_seq_if
// Description : Bundle of term-stream, control/status and shared FLP adder
//               operand/result signals for the accumulation sequencer.
//               The slave modport is the sequencer's view; the master modport
//               is the surrounding environment (term source + adder).
// Revision    : 1.0 - initial release
// ============================================================================
interface flp_accum_seq_if #(
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    // Control / status
    logic                  start;
    logic [CNT_WIDTH-1:0]  num_terms;
    logic                  busy;
    logic                  done;
    logic [EXP_WIDTH-1:0]  acc_exp;
    logic [MANT_WIDTH-1:0] acc_mant;

    // Term stream
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [MANT_WIDTH-1:0] in_mant;

    // Shared adder operands and result
    logic [EXP_WIDTH-1:0]  add_exp1;
    logic [MANT_WIDTH-1:0] add_mant1;
    logic [EXP_WIDTH-1:0]  add_exp2;
    logic [MANT_WIDTH-1:0] add_mant2;
    logic [EXP_WIDTH-1:0]  add_exp;
    logic [MANT_WIDTH-1:0] add_mant;

    modport master (
        output start, num_terms, in_valid, in_exp, in_mant, add_exp, add_mant,
        input  busy, done, acc_exp, acc_mant, in_ready,
               add_exp1, add_mant1, add_exp2, add_mant2
    );

    modport slave (
        input  start, num_terms, in_valid, in_exp, in_mant, add_exp, add_mant,
        output busy, done, acc_exp, acc_mant, in_ready,
               add_exp1, add_mant1, add_exp2, add_mant2
    );
endinterface
`default_nettype wire

// File: rtl/flp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : flp_accum_seq
// Description : Sequencer accumulating a stream of floating-point terms into a
//               running sum using a shared external FLP adder with fixed
//               latency ADD_LAT. The first term seeds the accumulator directly;
//               each later term is held and added over ADD_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module flp_accum_seq #(
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int ADD_LAT    = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    flp_accum_seq_if.slave  bus
);

    // Latency counter counts 0 .. ADD_LAT-1 inside the ADD state.
    localparam int c_LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(ADD_LAT - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FIRST     = 3'd1;
    localparam logic [2:0] c_S_WAIT_TERM = 3'd2;
    localparam logic [2:0] c_S_ADD       = 3'd3;
    localparam logic [2:0] c_S_DONE      = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [c_LAT_W-1:0]    r_lat_cnt;
    logic [EXP_WIDTH-1:0]  r_acc_exp;
    logic [MANT_WIDTH-1:0] r_acc_mant;
    logic [EXP_WIDTH-1:0]  r_hold_exp;
    logic [MANT_WIDTH-1:0] r_hold_mant;

    logic                  w_in_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_add_last;
    logic                  w_last_term;

    // Handshake and end-of-add qualifiers; in_ready is a pure state decode,
    // so in_valid only reaches registers, never in_ready.
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_add_last  = (r_state == c_S_ADD) && (r_lat_cnt == c_LAT_LAST);
    assign w_last_term = (r_remaining == c_CNT_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next_state = (bus.num_terms == '0) ? c_S_DONE : c_S_FIRST;
                end
            end
            c_S_FIRST: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = w_last_term ? c_S_DONE : c_S_WAIT_TERM;
                end
            end
            c_S_WAIT_TERM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = c_S_ADD;
                end
            end
            c_S_ADD: begin
                if (w_add_last) begin
                    w_next_state = w_last_term ? c_S_DONE : c_S_WAIT_TERM;
                end
            end
            c_S_DONE: begin
                w_done       = 1'b1;
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // Accumulator, held term, term counter and adder latency counter.
    // r_remaining holds the number of terms not yet folded into the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_lat_cnt   <= '0;
            r_acc_exp   <= '0;
            r_acc_mant  <= '0;
            r_hold_exp  <= '0;
            r_hold_mant <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_lat_cnt <= '0;
                    if (bus.start) begin
                        r_remaining <= bus.num_terms;
                        if (bus.num_terms == '0) begin
                            r_acc_exp  <= '0;
                            r_acc_mant <= '0;
                        end
                    end
                end
                c_S_FIRST: begin
                    if (w_accept) begin
                        r_acc_exp   <= bus.in_exp;
                        r_acc_mant  <= bus.in_mant;
                        r_remaining <= r_remaining - c_CNT_ONE;
                    end
                end
                c_S_WAIT_TERM: begin
                    r_lat_cnt <= '0;
                    if (w_accept) begin
                        r_hold_exp  <= bus.in_exp;
                        r_hold_mant <= bus.in_mant;
                    end
                end
                c_S_ADD: begin
                    if (w_add_last) begin
                        r_acc_exp   <= bus.add_exp;
                        r_acc_mant  <= bus.add_mant;
                        r_remaining <= r_remaining - c_CNT_ONE;
                        r_lat_cnt   <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
                    end
                end
                default: begin
                    r_lat_cnt <= '0;
                end
            endcase
        end
    end

    // Operand ports always mirror the accumulator and held registers.
    assign bus.add_exp1  = r_acc_exp;
    assign bus.add_mant1 = r_acc_mant;
    assign bus.add_exp2  = r_hold_exp;
    assign bus.add_mant2 = r_hold_mant;
    assign bus.acc_exp   = r_acc_exp;
    assign bus.acc_mant  = r_acc_mant;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_flp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_flp_accum_seq
// Description : Directed self-checking bench for flp_accum_seq with a
//               pipelined equal-exponent FLP adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flp_accum_seq;

    localparam int EXP_WIDTH  = 9;
    localparam int MANT_WIDTH = 8;
    localparam int CNT_WIDTH  = 4;
    localparam int ADD_LAT    = 2;

    logic clk;
    logic rst;

    flp_accum_seq_if #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) bus ();

    flp_accum_seq #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .ADD_LAT   (ADD_LAT)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Equal-exponent mantissa add; a carry out renormalises by one place.
    function automatic logic [16:0] fadd(input logic [16:0] a, input logic [16:0] b);
        logic [8:0] s;
        s = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        if (s[8]) return {a[16:8] + 9'd1, s[8:1]};
        return {a[16:8], s[7:0]};
    endfunction

    // Adder model: operands registered once, result read at the end of the
    // ADD_LAT-th cycle (ADD_LAT-1 register stages for ADD_LAT = 2).
    logic [16:0] r_add_res;
    always_ff @(posedge clk) begin
        r_add_res <= fadd({bus.add_exp1, bus.add_mant1}, {bus.add_exp2, bus.add_mant2});
    end
    assign bus.add_exp  = r_add_res[16:8];
    assign bus.add_mant = r_add_res[7:0];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-run stimulus and observations.
    logic [8:0] t_exp [4];
    logic [7:0] t_mant[4];
    int         t_dly [4];
    int         acc_cyc[4];
    int         done_cyc;
    int         done_cnt;
    int         ready_seen;
    bit         gap_ready_ok;

    task automatic set_terms(input logic [16:0] a, input logic [16:0] b,
                             input logic [16:0] c, input int dly1);
        t_exp[0] = a[16:8]; t_mant[0] = a[7:0];
        t_exp[1] = b[16:8]; t_mant[1] = b[7:0];
        t_exp[2] = c[16:8]; t_mant[2] = c[7:0];
        t_exp[3] = '0;      t_mant[3] = '0;
        t_dly[0] = 0; t_dly[1] = dly1; t_dly[2] = 0; t_dly[3] = 0;
    endtask

    // Issue start, then feed terms; cycle 0 is the first cycle after start.
    task automatic run_seq(input int n, input int pulse_cyc, input bit chk_ops);
        int cyc, idx, wait_cnt, win_k, win_lo, win_hi;
        bit acc_now, fin;
        logic [16:0] run;
        bus.num_terms = CNT_WIDTH'(n);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.num_terms = '0;
        cyc = 0; idx = 0; wait_cnt = t_dly[0]; win_k = 0; win_lo = 0; win_hi = -1;
        done_cnt = 0; done_cyc = -1; ready_seen = 0; gap_ready_ok = 1'b1; fin = 1'b0;
        run = '0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        while (!fin && cyc < 60) begin
            bus.in_valid  = (idx < n) && (wait_cnt == 0);
            bus.in_exp    = (idx < n) ? t_exp[idx]  : '0;
            bus.in_mant   = (idx < n) ? t_mant[idx] : '0;
            bus.start     = (cyc == pulse_cyc);
            bus.num_terms = (cyc == pulse_cyc) ? 4'd5 : 4'd0;
            if (bus.in_ready) ready_seen++;
            if (idx == 1 && wait_cnt > 0 && !bus.in_ready) gap_ready_ok = 1'b0;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now) acc_cyc[idx] = cyc;
            if (chk_ops && win_k > 0 && cyc >= win_lo && cyc <= win_hi) begin
                check_val("op1", {bus.add_exp1, bus.add_mant1}, run);
                check_val("op2", {bus.add_exp2, bus.add_mant2}, {t_exp[win_k], t_mant[win_k]});
                if (cyc == win_hi) run = fadd(run, {t_exp[win_k], t_mant[win_k]});
            end
            if (acc_now && idx == 0) run = {t_exp[0], t_mant[0]};
            if (acc_now && idx > 0) begin
                win_k  = idx;
                win_lo = cyc + 1;
                win_hi = cyc + ADD_LAT;
            end
            fin = (done_cnt > 0);
            tick();
            cyc++;
            if (acc_now) begin
                idx++;
                wait_cnt = (idx < n) ? t_dly[idx] : 0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.num_terms = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.num_terms = '0;
        bus.in_valid = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
        for (int i = 0; i < 4; i++) begin
            t_exp[i] = '0; t_mant[i] = '0; t_dly[i] = 0; acc_cyc[i] = -1;
        end
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_busy",  32'(bus.busy),     32'd0);
        check_val("rst_done",  32'(bus.done),     32'd0);
        check_val("rst_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_acc",   {bus.acc_exp, bus.acc_mant}, 32'h0);

        // Three equal-exponent terms, in_valid held high
        set_terms({9'd3, 8'h10}, {9'd3, 8'h20}, {9'd3, 8'h05}, 0);
        run_seq(3, -1, 1'b0);
        check_val("t3_acc0",  32'(acc_cyc[0]), 32'd0);
        check_val("t3_acc1",  32'(acc_cyc[1]), 32'd1);
        check_val("t3_acc2",  32'(acc_cyc[2]), 32'd4);
        check_val("t3_dcyc",  32'(done_cyc),   32'd7);
        check_val("t3_dcnt",  32'(done_cnt),   32'd1);
        check_val("t3_sum",   {bus.acc_exp, bus.acc_mant}, {9'd3, 8'h35});
        check_val("t3_idle",  32'(bus.busy),   32'd0);

        // Single term loads the accumulator directly
        set_terms({9'd7, 8'h42}, 17'h0, 17'h0, 0);
        run_seq(1, -1, 1'b0);
        check_val("t1_acc0",  32'(acc_cyc[0]), 32'd0);
        check_val("t1_dcyc",  32'(done_cyc),   32'd1);
        check_val("t1_sum",   {bus.acc_exp, bus.acc_mant}, {9'd7, 8'h42});
        // Result holds in IDLE
        tick(); tick();
        check_val("t1_hold",  {bus.acc_exp, bus.acc_mant}, {9'd7, 8'h42});

        // Zero terms: immediate done, cleared sum, never ready
        run_seq(0, -1, 1'b0);
        check_val("t0_dcyc",  32'(done_cyc),   32'd0);
        check_val("t0_rdy",   32'(ready_seen), 32'd0);
        check_val("t0_sum",   {bus.acc_exp, bus.acc_mant}, 32'h0);

        // Stalling source: second term five cycles late
        set_terms({9'd5, 8'h30}, {9'd5, 8'h41}, 17'h0, 5);
        run_seq(2, -1, 1'b1);
        check_val("st_gap",   32'(gap_ready_ok), 32'd1);
        check_val("st_acc1",  32'(acc_cyc[1]),   32'd6);
        check_val("st_dcyc",  32'(done_cyc),     32'd9);
        check_val("st_sum",   {bus.acc_exp, bus.acc_mant}, {9'd5, 8'h71});

        // Start pulsed mid-run with a different count is ignored
        set_terms({9'd4, 8'h11}, {9'd4, 8'h22}, 17'h0, 0);
        run_seq(2, 2, 1'b0);
        check_val("sp_dcyc",  32'(done_cyc),   32'd4);
        check_val("sp_dcnt",  32'(done_cnt),   32'd1);
        check_val("sp_sum",   {bus.acc_exp, bus.acc_mant}, {9'd4, 8'h33});
        check_val("sp_idle",  32'(bus.busy),   32'd0);

        // Reset asserted during ADD abandons the sum
        bus.num_terms = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.num_terms = '0;
        bus.in_valid = 1'b1; bus.in_exp = 9'd2; bus.in_mant = 8'h01;
        tick();
        bus.in_exp = 9'd2; bus.in_mant = 8'h02;
        tick();
        bus.in_valid = 1'b0;
        check_val("ra_ready", 32'(bus.in_ready), 32'd0);
        check_val("ra_op2",   {bus.add_exp2, bus.add_mant2}, {9'd2, 8'h02});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("ra_busy",  32'(bus.busy),   32'd0);
        check_val("ra_done",  32'(bus.done),   32'd0);
        check_val("ra_acc",   {bus.acc_exp, bus.acc_mant}, 32'h0);
        check_val("ra_held",  {bus.add_exp2, bus.add_mant2}, 32'h0);
        tick();
        check_val("ra_nodone", 32'(bus.done),  32'd0);

        // Clean run after reset, with a mantissa carry in the adder
        set_terms({9'd6, 8'hC0}, {9'd6, 8'h80}, 17'h0, 0);
        run_seq(2, -1, 1'b1);
        check_val("pr_dcyc",  32'(done_cyc),   32'd4);
        check_val("pr_sum",   {bus.acc_exp, bus.acc_mant}, {9'd7, 8'hA0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
